// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared definitions for the SDRAM row controller: command
//                op encodings, controller state encoding, row geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // Command op encodings carried on cmd_op (PRE is signalled on cmd_pre)
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ACT = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

    // Default row geometry
    localparam int COL_BITS_DEFAULT = 6;
    localparam int WORDS_PER_ROW    = 2**COL_BITS_DEFAULT;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACTIVATING = 3'd1,
        ST_ACTIVE     = 3'd2,
        ST_WRITEBACK  = 3'd3,
        ST_PRECHARGE  = 3'd4
    } state_t;

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/rowctrl_cas_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rowctrl_cas_pipe
//  Description : DEPTH-stage valid/data shift register that delays a read
//                word by the CAS latency. The output data register only
//                advances when a valid word arrives, so rd_data holds the
//                most recently delivered word between reads. DEPTH >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rowctrl_cas_pipe
    import sdram_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;

    // Shift valid every cycle; move data only behind a valid bit
    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = in_valid;
        if (in_valid) begin
            dat_d[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    // Pipeline registers, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule : rowctrl_cas_pipe
`default_nettype wire

// File: rtl/sdram_row_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_row_ctrl
//  Description : Command front-end for the memory core array. Accepts
//                ACT/RD/WR/PRE, opens a row into a local row buffer, serves
//                column reads/writes from the buffer and writes the buffer
//                back to the core on PRE.
//                Optional build macro ROWCTRL_DIRTY_SKIP_EN: PRE of a row
//                that saw no WR skips the write-back cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_row_ctrl
    import sdram_pkg::*;
#(
    parameter int ROW_ADDR_BITWIDTH = 8,
    parameter int COL_ADDR_BITWIDTH = 6,
    parameter int DATA_BIT_WIDTH    = 32,
    parameter int T_RCD             = 3,
    parameter int CAS_LAT           = 2,
    parameter int T_RP              = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  cmd_valid,
    output logic                                                  cmd_ready,
    input  logic [1:0]                                            cmd_op,
    input  logic                                                  cmd_pre,
    input  logic [ROW_ADDR_BITWIDTH-1:0]                          cmd_row,
    input  logic [COL_ADDR_BITWIDTH-1:0]                          cmd_col,
    input  logic [DATA_BIT_WIDTH-1:0]                             cmd_wdata,
    output logic                                                  rd_valid,
    output logic [DATA_BIT_WIDTH-1:0]                             rd_data,
    output logic                                                  cmd_err,
    output logic                                                  row_open,
    output logic [2**ROW_ADDR_BITWIDTH-1:0]                       RowAddrEn,
    output logic                                                  RE,
    output logic                                                  WE,
    output logic [(2**COL_ADDR_BITWIDTH)*DATA_BIT_WIDTH-1:0]      mem_wdata,
    input  logic [(2**COL_ADDR_BITWIDTH)*DATA_BIT_WIDTH-1:0]      mem_rdata
);

    localparam int c_rows  = 2**ROW_ADDR_BITWIDTH;
    localparam int c_words = 2**COL_ADDR_BITWIDTH;
    localparam int c_cnt_w = 8;

    // ACTIVATING spans T_RCD-1 cycles, PRECHARGE spans T_RP cycles; each
    // counter is loaded with (cycles in state - 1) and the state is left
    // on the cycle it reads zero.
    localparam logic [c_cnt_w-1:0] c_rcd_load = c_cnt_w'(T_RCD - 2);
    localparam logic [c_cnt_w-1:0] c_rp_load  = c_cnt_w'(T_RP - 1);

    state_t                                  state_q, state_d;
    logic [c_cnt_w-1:0]                      cnt_q, cnt_d;
    logic [ROW_ADDR_BITWIDTH-1:0]            row_q, row_d;
    logic [c_words-1:0][DATA_BIT_WIDTH-1:0]  buf_q, buf_d;
    logic                                    cmd_err_q, cmd_err_d;
`ifdef ROWCTRL_DIRTY_SKIP_EN
    logic                                    dirty_q, dirty_d;
`endif

    logic                                    accept;
    logic                                    rd_push;
    logic [DATA_BIT_WIDTH-1:0]               rd_word;
    logic                                    row_strobe;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign accept    = cmd_valid && cmd_ready;
    assign rd_word   = buf_q[cmd_col];

    // Next-state, counters, row buffer and error pulse
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        buf_d     = buf_q;
        cmd_err_d = 1'b0;
        rd_push   = 1'b0;
`ifdef ROWCTRL_DIRTY_SKIP_EN
        dirty_d   = dirty_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_pre) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_ACT: begin
                                row_d   = cmd_row;
                                cnt_d   = c_rcd_load;
                                state_d = ST_ACTIVATING;
                            end
                            OP_RD, OP_WR: cmd_err_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_ACTIVATING: begin
                // The core presents the row during the RE cycle
                if (cnt_q == c_rcd_load) begin
                    buf_d = mem_rdata;
`ifdef ROWCTRL_DIRTY_SKIP_EN
                    dirty_d = 1'b0;
`endif
                end
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (cmd_pre) begin
`ifdef ROWCTRL_DIRTY_SKIP_EN
                        if (dirty_q) begin
                            state_d = ST_WRITEBACK;
                        end else begin
                            cnt_d   = c_rp_load;
                            state_d = ST_PRECHARGE;
                        end
`else
                        state_d = ST_WRITEBACK;
`endif
                    end else begin
                        case (cmd_op)
                            OP_ACT: cmd_err_d = 1'b1;
                            OP_RD:  rd_push   = 1'b1;
                            OP_WR: begin
                                buf_d[cmd_col] = cmd_wdata;
`ifdef ROWCTRL_DIRTY_SKIP_EN
                                dirty_d = 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WRITEBACK: begin
                cnt_d   = c_rp_load;
                state_d = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers; reset abandons any pending write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            buf_q     <= '0;
            cmd_err_q <= 1'b0;
`ifdef ROWCTRL_DIRTY_SKIP_EN
            dirty_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            buf_q     <= buf_d;
            cmd_err_q <= cmd_err_d;
`ifdef ROWCTRL_DIRTY_SKIP_EN
            dirty_q   <= dirty_d;
`endif
        end
    end

    // Core strobes decode from state alone, so RE and WE are exclusive
    assign RE         = (state_q == ST_ACTIVATING) && (cnt_q == c_rcd_load);
    assign WE         = (state_q == ST_WRITEBACK);
    assign row_strobe = RE || WE;
    assign RowAddrEn  = row_strobe ? (c_rows'(1) << row_q) : '0;
    assign mem_wdata  = buf_q;
    assign row_open   = (state_q == ST_ACTIVE);
    assign cmd_err    = cmd_err_q;

    rowctrl_cas_pipe #(
        .DEPTH  (CAS_LAT),
        .DATA_W (DATA_BIT_WIDTH)
    ) u_cas_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_push),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule : sdram_row_ctrl
`default_nettype wire
